// File: rtl/simd_bilinear_pipe.sv
// simd_bilinear_pipe: N-lane bilinear interpolation engine, 3-stage stallable
// pipeline (S1 horizontal blend, S2 vertical blend, S3 round + output register),
// per-beat lane-enable mask and a frame beat counter with a frame_done pulse.
// Ports:
//   clk, rst (async, active-low), soft_clr (sync flush/clear, latches cfg_frame_len)
//   cfg_lane_en[N], cfg_frame_len[CNT_W]
//   in_valid / in_ready, I00_vec..I11_vec [N][W], alpha_vec / beta_vec [N][FW]
//   out_valid / out_ready, out_lane_valid[N], pixel_out_vec [N][W]
//   beat_count[CNT_W], frame_done

// One lane of the datapath. Stage load enables come from the shared stall chain.
// The enable bit of a bubble is 0, so bubbles and disabled lanes both carry 0.
module simd_bilinear_lane #(
  parameter int W  = 8,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld1,
  input  logic          ld2,
  input  logic          ld3,
  input  logic          take,
  input  logic          v1,
  input  logic          v2,
  input  logic          en,
  input  logic [W-1:0]  i00,
  input  logic [W-1:0]  i10,
  input  logic [W-1:0]  i01,
  input  logic [W-1:0]  i11,
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic          lane_valid,
  output logic [W-1:0]  pix
);
  localparam int HW = W + FW + 1;
  localparam int VW = W + 2*FW + 2;
  localparam logic [FW:0]   SCALE = {1'b1, {FW{1'b0}}};
  localparam logic [VW-1:0] HALF  = VW'(1) << (2*FW - 1);

  logic [FW:0]   na, nb;
  logic [HW-1:0] h0_n, h1_n, h0, h1;
  logic [FW-1:0] b1;
  logic [VW-1:0] v_n, v;
  logic [W-1:0]  p_n, p;
  logic          e1, e2, e3;

  assign na   = SCALE - {1'b0, a};
  assign h0_n = HW'(i00) * HW'(na) + HW'(i10) * HW'(a);
  assign h1_n = HW'(i01) * HW'(na) + HW'(i11) * HW'(a);
  // beta is consumed one stage later, so it rides along in S1
  assign nb   = SCALE - {1'b0, b1};
  assign v_n  = VW'(h0) * VW'(nb) + VW'(h1) * VW'(b1);
  assign p_n  = W'((v + HALF) >> (2*FW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h0 <= '0; h1 <= '0; b1 <= '0; v <= '0; p <= '0;
      e1 <= 1'b0; e2 <= 1'b0; e3 <= 1'b0;
    end else if (clr) begin
      e1 <= 1'b0; e2 <= 1'b0; e3 <= 1'b0; p <= '0;
    end else begin
      if (ld1) begin
        h0 <= h0_n; h1 <= h1_n; b1 <= b;
        e1 <= take & en;
      end
      if (ld2) begin
        v  <= v_n;
        e2 <= v1 & e1;
      end
      if (ld3) begin
        e3 <= v2 & e2;
        p  <= (v2 & e2) ? p_n : '0;
      end
    end
  end

  assign lane_valid = e3;
  assign pix        = p;
endmodule

module simd_bilinear_pipe #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int FW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_clr,
  input  logic [N-1:0]          cfg_lane_en,
  input  logic [CNT_W-1:0]      cfg_frame_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][W-1:0]   I00_vec,
  input  logic [N-1:0][W-1:0]   I10_vec,
  input  logic [N-1:0][W-1:0]   I01_vec,
  input  logic [N-1:0][W-1:0]   I11_vec,
  input  logic [N-1:0][FW-1:0]  alpha_vec,
  input  logic [N-1:0][FW-1:0]  beta_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_lane_valid,
  output logic [N-1:0][W-1:0]   pixel_out_vec,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  frame_done
);
  logic [3:1]       vld_pipe;
  logic             ld1, ld2, ld3, accept, xfer, frame_hit;
  logic [CNT_W-1:0] len_q, cnt_inc;

  // Stall chain: a stage loads when empty or when its content moves on.
  assign ld3      = !vld_pipe[3] | out_ready;
  assign ld2      = !vld_pipe[2] | ld3;
  assign ld1      = !vld_pipe[1] | ld2;
  assign in_ready = ld1 & !soft_clr;
  assign accept   = in_valid & in_ready;
  assign out_valid = vld_pipe[3];
  // A transfer coinciding with soft_clr is discarded and not counted
  assign xfer      = vld_pipe[3] & out_ready & !soft_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_pipe <= '0;
    else if (soft_clr)
      vld_pipe <= '0;
    else begin
      if (ld1) vld_pipe[1] <= accept;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    simd_bilinear_lane #(.W(W), .FW(FW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clr        (soft_clr),
      .ld1        (ld1),
      .ld2        (ld2),
      .ld3        (ld3),
      .take       (accept),
      .v1         (vld_pipe[1]),
      .v2         (vld_pipe[2]),
      .en         (cfg_lane_en[i]),
      .i00        (I00_vec[i]),
      .i10        (I10_vec[i]),
      .i01        (I01_vec[i]),
      .i11        (I11_vec[i]),
      .a          (alpha_vec[i]),
      .b          (beta_vec[i]),
      .lane_valid (out_lane_valid[i]),
      .pix        (pixel_out_vec[i])
    );
  end

  // Frame counter; length 0 means free-running wrap at 2^CNT_W
  assign cnt_inc    = beat_count + CNT_W'(1);
  assign frame_hit  = (len_q != '0) && (cnt_inc == len_q);
  assign frame_done = xfer & frame_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count <= '0;
      len_q      <= '0;
    end else if (soft_clr) begin
      beat_count <= '0;
      len_q      <= cfg_frame_len;
    end else if (xfer) begin
      beat_count <= frame_hit ? '0 : cnt_inc;
    end
  end
endmodule

// File: tb/tb_simd_bilinear_pipe.sv
// Directed bench for simd_bilinear_pipe (N=4, W=8, FW=8, CNT_W=16).
module tb_simd_bilinear_pipe;
  localparam int N = 4, W = 8, FW = 8, CNT_W = 16;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic                 soft_clr, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [N-1:0]         cfg_lane_en, out_lane_valid;
  logic [CNT_W-1:0]     cfg_frame_len, beat_count;
  logic [N-1:0][W-1:0]  I00_vec, I10_vec, I01_vec, I11_vec, pixel_out_vec;
  logic [N-1:0][FW-1:0] alpha_vec, beta_vec;

  simd_bilinear_pipe #(.N(N), .W(W), .FW(FW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr), .cfg_lane_en(cfg_lane_en),
    .cfg_frame_len(cfg_frame_len), .in_valid(in_valid), .in_ready(in_ready),
    .I00_vec(I00_vec), .I10_vec(I10_vec), .I01_vec(I01_vec), .I11_vec(I11_vec),
    .alpha_vec(alpha_vec), .beta_vec(beta_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .pixel_out_vec(pixel_out_vec), .beat_count(beat_count), .frame_done(frame_done)
  );

  int n_chk = 0, n_pass = 0;
  logic [31:0] pix_q[$];
  logic [3:0]  lv_q[$];
  logic        fd_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output collector: records every accepted output transfer
  always @(negedge clk)
    if (rst && out_valid && out_ready && !soft_clr) begin
      pix_q.push_back(pixel_out_vec);
      lv_q.push_back(out_lane_valid);
      fd_q.push_back(frame_done);
    end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic flush_q;
    pix_q.delete(); lv_q.delete(); fd_q.delete();
  endtask

  // Per-lane distinct pixel pattern; with A=B=0 the output equals I00
  function automatic logic [31:0] pat(input int k);
    return {8'(10*k + 4), 8'(10*k + 3), 8'(10*k + 2), 8'(10*k + 1)};
  endfunction

  task automatic set_beat(input logic [31:0] i00, i10, i01, i11, a, b, input logic [3:0] en);
    I00_vec = i00; I10_vec = i10; I01_vec = i01; I11_vec = i11;
    alpha_vec = a; beta_vec = b; cfg_lane_en = en; in_valid = 1'b1;
  endtask

  task automatic drain(input string tag, input int n);
    int c = 0;
    while (pix_q.size() < n && c < 50) begin tick; c++; end
    chk(tag, pix_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] fdv;
    int k;
    logic acc;
    soft_clr = 0; in_valid = 0; out_ready = 1; cfg_frame_len = '0; cfg_lane_en = '0;
    I00_vec = '0; I10_vec = '0; I01_vec = '0; I11_vec = '0; alpha_vec = '0; beta_vec = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pixel", pixel_out_vec, 0);
    chk("rst_lane_valid", out_lane_valid, 0);
    rst = 1'b1; #1;
    chk("rst_in_ready", in_ready, 1);
    tick;

    // T1: midpoint blend -> 25 on all lanes at t+3
    set_beat(32'h0a0a0a0a, 32'h14141414, 32'h1e1e1e1e, 32'h28282828,
             32'h80808080, 32'h80808080, 4'hf);
    #1 chk("t1_in_ready", in_ready, 1);
    tick; in_valid = 0; #1;
    chk("t1_lat1", out_valid, 0);
    tick; chk("t1_lat2", out_valid, 0);
    tick; chk("t1_lat3", out_valid, 1);
    chk("t1_pix", pixel_out_vec, 32'h19191919);
    chk("t1_lv", out_lane_valid, 4'hf);

    // T2: corners, lanes {3,2,1,0} -> {200,255,254,77}
    tick;
    set_beat(32'h64FF004D, 32'h21FFFF09, 32'hC8FF1103, 32'h05FF63FA,
             32'h0025FF00, 32'hFFC80000, 4'hf);
    tick; in_valid = 0;
    tick; tick;
    chk("t2_valid", out_valid, 1);
    chk("t2_pix", pixel_out_vec, 32'hC8FFFE4D);
    tick;

    // T3: 8-beat stream, 5-cycle downstream stall
    flush_q(); k = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (k < 8) set_beat(pat(k), '0, '0, '0, '0, '0, 4'hf);
      else in_valid = 0;
      #1;
      if (c == 2) chk("t3_rdy_pre", in_ready, 1);
      if (c >= 3 && c <= 7) chk("t3_rdy_stall", in_ready, 0);
      if (c == 7) begin
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_pix", pixel_out_vec, pat(0));
      end
      if (c == 8) chk("t3_rdy_post", in_ready, 1);
      acc = in_valid && in_ready;
      tick;
      if (acc) k++;
    end
    in_valid = 0; out_ready = 1;
    chk("t3_count", pix_q.size(), 8);
    for (int j = 0; j < 8 && j < pix_q.size(); j++)
      chk("t3_order", pix_q[j], pat(j));

    // T4: lane mask 0101 then 1111
    flush_q();
    set_beat(pat(20), '0, '0, '0, '0, '0, 4'b0101); tick;
    set_beat(pat(21), '0, '0, '0, '0, '0, 4'b1111); tick;
    in_valid = 0;
    drain("t4_drain", 2);
    if (pix_q.size() >= 2) begin
      chk("t4_pix_masked", pix_q[0], pat(20) & 32'h00FF00FF);
      chk("t4_lv_masked", lv_q[0], 4'b0101);
      chk("t4_pix_full", pix_q[1], pat(21));
      chk("t4_lv_full", lv_q[1], 4'b1111);
    end

    // T5: frame length 4, 9 beats
    flush_q();
    cfg_frame_len = 16'd4; soft_clr = 1; in_valid = 0;
    #1 chk("t5_clr_rdy", in_ready, 0);
    tick; soft_clr = 0;
    chk("t5_cnt_clr", beat_count, 0);
    for (int j = 0; j < 9; j++) begin
      set_beat(pat(j), '0, '0, '0, '0, '0, 4'hf);
      tick;
    end
    in_valid = 0;
    drain("t5_drain", 9);
    fdv = '0;
    for (int j = 0; j < 9 && j < fd_q.size(); j++) fdv[j] = fd_q[j];
    chk("t5_frame_done", fdv, 9'b010001000);
    chk("t5_cnt_end", beat_count, 1);

    // T6: soft_clr with 3 beats in flight
    flush_q();
    for (int j = 0; j < 3; j++) begin
      set_beat(pat(10 + j), '0, '0, '0, '0, '0, 4'hf);
      tick;
    end
    in_valid = 0; soft_clr = 1;
    #1;
    chk("t6_inflight", out_valid, 1);
    chk("t6_clr_rdy", in_ready, 0);
    tick; soft_clr = 0;
    chk("t6_flushed", out_valid, 0);
    chk("t6_cnt_clr", beat_count, 0);
    set_beat(pat(13), '0, '0, '0, '0, '0, 4'hf);
    tick; in_valid = 0;
    chk("t6_lat1", out_valid, 0);
    tick; chk("t6_lat2", out_valid, 0);
    tick; chk("t6_lat3", out_valid, 1);
    chk("t6_pix", pixel_out_vec, pat(13));
    tick;
    chk("t6_count", pix_q.size(), 1);
    chk("t6_cnt_end", beat_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
